// File: rtl/fpu_cmp_pkg.sv
// Shared types and helpers for the pipelined floating-point compare unit.
package fpu_cmp_pkg;

  // Operation selector; encodings 5..7 are reserved and complete with y=0, z=0.
  typedef enum logic [2:0] {
    FCMP_EQ  = 3'd0,
    FCMP_LT  = 3'd1,
    FCMP_LE  = 3'd2,
    FCMP_MIN = 3'd3,
    FCMP_MAX = 3'd4
  } fcmp_op_t;

  // Per-operand classification.
  typedef struct packed {
    logic is_zero;
    logic is_nan;
    logic sign;
  } classify_t;

  // Widest operand the qNaN helper can build.
  localparam int CANON_MAX_W = 64;

  // Canonical quiet NaN {0, all-ones exponent, 1, zeros}, right-aligned in 64 bits.
  function automatic logic [CANON_MAX_W-1:0] canon_qnan(input int exp_w, input int man_w);
    logic [CANON_MAX_W-1:0] r;
    r = {CANON_MAX_W{1'b0}};
    for (int i = 0; i < exp_w; i++) begin
      r[man_w + i] = 1'b1;
    end
    r[man_w - 1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/fcmp_pipe_if.sv
// Handshake bundle for the compare unit: operand/op input side and result output side.
interface fcmp_pipe_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x1;
  logic [W-1:0] x2;
  logic [2:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic         y;
  logic [W-1:0] z;

  // Requester side: supplies operands and consumes results.
  modport master (
    output in_valid, x1, x2, op, out_ready,
    input  in_ready, out_valid, y, z
  );

  // Compare unit side.
  modport slave (
    input  in_valid, x1, x2, op, out_ready,
    output in_ready, out_valid, y, z
  );
endinterface

// File: rtl/fcmp_core.sv
// Combinational classify plus less-than / equal decision for one operand pair.
// Zeros (exponent==0) are flushed to an unsigned zero magnitude so +0/-0 and
// denormals all compare equal. NaN flags are reported but not applied here.
module fcmp_core
  import fpu_cmp_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int NAN_EN = 1
) (
  input  logic [EXP_W+MAN_W:0] a_i,
  input  logic [EXP_W+MAN_W:0] b_i,
  output logic                 nan_a_o,
  output logic                 nan_b_o,
  output logic                 lt_o,
  output logic                 eq_o
);

  localparam int MAG_W = EXP_W + MAN_W;

  function automatic classify_t classify(input logic [MAG_W:0] v);
    classify_t c;
    c.is_zero = (v[MAG_W-1 -: EXP_W] == {EXP_W{1'b0}});
    c.is_nan  = (NAN_EN != 0) &&
                (v[MAG_W-1 -: EXP_W] == {EXP_W{1'b1}}) &&
                (v[MAN_W-1:0] != {MAN_W{1'b0}});
    c.sign    = v[MAG_W];
    return c;
  endfunction

  classify_t        cls_a_s;
  classify_t        cls_b_s;
  logic [MAG_W-1:0] mag_a_s;
  logic [MAG_W-1:0] mag_b_s;
  logic             neg_a_s;
  logic             neg_b_s;

  // Classify both operands and derive flushed magnitude and effective sign.
  always_comb begin
    cls_a_s = classify(a_i);
    cls_b_s = classify(b_i);
    mag_a_s = cls_a_s.is_zero ? {MAG_W{1'b0}} : a_i[MAG_W-1:0];
    mag_b_s = cls_b_s.is_zero ? {MAG_W{1'b0}} : b_i[MAG_W-1:0];
    neg_a_s = cls_a_s.sign & ~cls_a_s.is_zero;
    neg_b_s = cls_b_s.sign & ~cls_b_s.is_zero;
  end

  // Sign-magnitude ordering: negatives below positives, magnitude reversed among negatives.
  always_comb begin
    lt_o = 1'b0;
    eq_o = (neg_a_s == neg_b_s) && (mag_a_s == mag_b_s);
    if (neg_a_s != neg_b_s) begin
      lt_o = neg_a_s;
    end else if (neg_a_s) begin
      lt_o = (mag_a_s > mag_b_s);
    end else begin
      lt_o = (mag_a_s < mag_b_s);
    end
  end

  assign nan_a_o = cls_a_s.is_nan;
  assign nan_b_o = cls_b_s.is_nan;

endmodule

// File: rtl/fcmp_pipe.sv
// Pipelined floating-point compare unit (EQ/LT/LE/MIN/MAX) with ready/valid on both
// sides. Stage 1 captures the core's NaN flags and lt/eq decision with the operands;
// the output register captures the op mux. Any middle stage is pure delay.
// One global stall freezes every stage, bubbles included, so results stay in order.
module fcmp_pipe
  import fpu_cmp_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int LAT    = 2,
  parameter int NAN_EN = 1
) (
  input  logic       clk,
  input  logic       rst,
  fcmp_pipe_if.slave bus
);

  localparam int W = 1 + EXP_W + MAN_W;
  localparam logic [W-1:0] QNAN = W'(canon_qnan(EXP_W, MAN_W));

  typedef struct packed {
    logic         valid;
    logic         nan1;
    logic         nan2;
    logic         lt;
    logic         eq;
    logic [2:0]   op;
    logic [W-1:0] x1;
    logic [W-1:0] x2;
  } stage_t;

  logic         core_nan1_s;
  logic         core_nan2_s;
  logic         core_lt_s;
  logic         core_eq_s;
  logic         stall_s;
  stage_t       feed_s;
  stage_t       src_s;
  stage_t       pipe_s [LAT];
  logic         out_valid_q;
  logic         y_q;
  logic [W-1:0] z_q;
  logic         y_d;
  logic [W-1:0] z_d;

  fcmp_core #(
    .EXP_W  (EXP_W),
    .MAN_W  (MAN_W),
    .NAN_EN (NAN_EN)
  ) u_core (
    .a_i     (bus.x1),
    .b_i     (bus.x2),
    .nan_a_o (core_nan1_s),
    .nan_b_o (core_nan2_s),
    .lt_o    (core_lt_s),
    .eq_o    (core_eq_s)
  );

  assign stall_s       = out_valid_q & ~bus.out_ready;
  assign bus.in_ready  = ~stall_s;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.z         = z_q;

  // Pack the incoming operands with their core decision; valid only on a real transfer.
  always_comb begin
    feed_s.valid = bus.in_valid & ~stall_s;
    feed_s.nan1  = core_nan1_s;
    feed_s.nan2  = core_nan2_s;
    feed_s.lt    = core_lt_s;
    feed_s.eq    = core_eq_s;
    feed_s.op    = bus.op;
    feed_s.x1    = bus.x1;
    feed_s.x2    = bus.x2;
  end

  assign pipe_s[0] = feed_s;

  for (genvar g = 1; g < LAT; g++) begin : g_stage
    stage_t stage_q;

    // Advance one slot per unstalled cycle; hold (including bubbles) while stalled.
    always_ff @(posedge clk) begin
      if (rst) begin
        stage_q <= '0;
      end else if (!stall_s) begin
        stage_q <= pipe_s[g-1];
      end else begin
        stage_q <= stage_q;
      end
    end

    assign pipe_s[g] = stage_q;
  end

  assign src_s = pipe_s[LAT-1];

  // Op mux: predicates are masked by NaN, MIN/MAX fall back to the non-NaN operand.
  always_comb begin
    y_d = 1'b0;
    z_d = {W{1'b0}};
    if (src_s.valid) begin
      case (fcmp_op_t'(src_s.op))
        FCMP_EQ: begin
          y_d = ~(src_s.nan1 | src_s.nan2) & src_s.eq;
        end
        FCMP_LT: begin
          y_d = ~(src_s.nan1 | src_s.nan2) & src_s.lt;
        end
        FCMP_LE: begin
          y_d = ~(src_s.nan1 | src_s.nan2) & (src_s.lt | src_s.eq);
        end
        FCMP_MIN: begin
          if (src_s.nan1 && src_s.nan2) begin
            z_d = QNAN;
          end else if (src_s.nan1) begin
            z_d = src_s.x2;
          end else if (src_s.nan2) begin
            z_d = src_s.x1;
          end else if (src_s.lt || src_s.eq) begin
            z_d = src_s.x1;
          end else begin
            z_d = src_s.x2;
          end
        end
        FCMP_MAX: begin
          if (src_s.nan1 && src_s.nan2) begin
            z_d = QNAN;
          end else if (src_s.nan1) begin
            z_d = src_s.x2;
          end else if (src_s.nan2) begin
            z_d = src_s.x1;
          end else if (src_s.lt) begin
            z_d = src_s.x2;
          end else begin
            z_d = src_s.x1;
          end
        end
        default: begin
          y_d = 1'b0;
          z_d = {W{1'b0}};
        end
      endcase
    end else begin
      y_d = 1'b0;
      z_d = {W{1'b0}};
    end
  end

  // Output register: loads the mux result unless the consumer is stalling us.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      y_q         <= 1'b0;
      z_q         <= {W{1'b0}};
    end else if (!stall_s) begin
      out_valid_q <= src_s.valid;
      y_q         <= y_d;
      z_q         <= z_d;
    end else begin
      out_valid_q <= out_valid_q;
      y_q         <= y_q;
      z_q         <= z_q;
    end
  end

endmodule

// File: tb/tb_fcmp_pipe.sv
// Self-checking bench for fcmp_pipe: hand vectors on the default configuration,
// backpressure and mid-stream reset sequences, then LAT=1/LAT=3 sweeps (NAN_EN=0)
// against an independent ordered-key reference model.
module tb_fcmp_pipe;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] x1;
    logic [31:0] x2;
    logic        y;
    logic [31:0] z;
  } vec_t;

  typedef struct packed {
    logic        y;
    logic [31:0] z;
  } res_t;

  localparam int NVEC = 20;
  localparam int NSW  = 150;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   fails  = 0;

  fcmp_pipe_if #(.W(32)) bus_a ();
  fcmp_pipe_if #(.W(32)) bus_b ();
  fcmp_pipe_if #(.W(32)) bus_c ();

  fcmp_pipe #(.EXP_W(8), .MAN_W(23), .LAT(2), .NAN_EN(1)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a.slave));
  fcmp_pipe #(.EXP_W(8), .MAN_W(23), .LAT(1), .NAN_EN(0)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b.slave));
  fcmp_pipe #(.EXP_W(8), .MAN_W(23), .LAT(3), .NAN_EN(0)) dut_c (
    .clk (clk), .rst (rst), .bus (bus_c.slave));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: map each value to a signed integer key (zero -> 0) and compare keys.
  function automatic longint key_of(input logic [31:0] v);
    if (v[30:23] == 8'd0) return 64'sd0;
    if (v[31]) return -longint'(v[30:0]);
    return longint'(v[30:0]);
  endfunction

  function automatic res_t ref_cmp(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input bit nan_en);
    res_t   r;
    bit     na;
    bit     nb;
    longint ka;
    longint kb;
    r  = '0;
    na = nan_en && (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    nb = nan_en && (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    ka = key_of(a);
    kb = key_of(b);
    case (op)
      3'd0: r.y = !(na || nb) && (ka == kb);
      3'd1: r.y = !(na || nb) && (ka < kb);
      3'd2: r.y = !(na || nb) && (ka <= kb);
      3'd3: r.z = (na && nb) ? 32'h7FC00000 : na ? b : nb ? a : (kb < ka) ? b : a;
      3'd4: r.z = (na && nb) ? 32'h7FC00000 : na ? b : nb ? a : (kb > ka) ? b : a;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [7:0]  e;
    logic [22:0] m;
    case ($urandom_range(0, 5))
      0: e = 8'h00;
      1: e = 8'hFF;
      2: e = 8'h7F;
      3: e = 8'h80;
      default: e = 8'($urandom_range(0, 255));
    endcase
    case ($urandom_range(0, 3))
      0: m = 23'd0;
      1: m = 23'd1;
      default: m = 23'($urandom);
    endcase
    return {1'($urandom_range(0, 1)), e, m};
  endfunction

  vec_t        vecs [NVEC];
  logic [2:0]  sop  [NSW];
  logic [31:0] sx1  [NSW];
  logic [31:0] sx2  [NSW];
  res_t        sexp [NSW];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{3'd1, 32'h3F800000, 32'h40000000, 1'b1, 32'h0};
    vecs[1]  = '{3'd1, 32'hBF800000, 32'hC0000000, 1'b0, 32'h0};
    vecs[2]  = '{3'd1, 32'hBF800000, 32'h3F800000, 1'b1, 32'h0};
    vecs[3]  = '{3'd0, 32'h00000000, 32'h80000000, 1'b1, 32'h0};
    vecs[4]  = '{3'd0, 32'h00000001, 32'h80000000, 1'b1, 32'h0};
    vecs[5]  = '{3'd1, 32'h00000000, 32'h80000000, 1'b0, 32'h0};
    vecs[6]  = '{3'd1, 32'h00000001, 32'h80000000, 1'b0, 32'h0};
    vecs[7]  = '{3'd2, 32'h7FC00000, 32'h3F800000, 1'b0, 32'h0};
    vecs[8]  = '{3'd3, 32'h7FC00000, 32'hC0000000, 1'b0, 32'hC0000000};
    vecs[9]  = '{3'd4, 32'h7FC00001, 32'hFFC00000, 1'b0, 32'h7FC00000};
    vecs[10] = '{3'd3, 32'h3F800000, 32'hC0000000, 1'b0, 32'hC0000000};
    vecs[11] = '{3'd4, 32'h3F800000, 32'hC0000000, 1'b0, 32'h3F800000};
    vecs[12] = '{3'd3, 32'h00000000, 32'h80000000, 1'b0, 32'h00000000};
    vecs[13] = '{3'd4, 32'h80000000, 32'h00000000, 1'b0, 32'h80000000};
    vecs[14] = '{3'd3, 32'h00000005, 32'h80000000, 1'b0, 32'h00000005};
    vecs[15] = '{3'd5, 32'h3F800000, 32'h40000000, 1'b0, 32'h0};
    vecs[16] = '{3'd2, 32'h40000000, 32'h40000000, 1'b1, 32'h0};
    vecs[17] = '{3'd0, 32'h7FC00000, 32'h7FC00000, 1'b0, 32'h0};
    vecs[18] = '{3'd4, 32'h7F800000, 32'h7FC00000, 1'b0, 32'h7F800000};
    vecs[19] = '{3'd2, 32'hC0000000, 32'hBF800000, 1'b1, 32'h0};

    bus_a.in_valid = 1'b0; bus_a.op = 3'd0; bus_a.x1 = 32'd0; bus_a.x2 = 32'd0; bus_a.out_ready = 1'b1;
    bus_b.in_valid = 1'b0; bus_b.op = 3'd0; bus_b.x1 = 32'd0; bus_b.x2 = 32'd0; bus_b.out_ready = 1'b1;
    bus_c.in_valid = 1'b0; bus_c.op = 3'd0; bus_c.x1 = 32'd0; bus_c.x2 = 32'd0; bus_c.out_ready = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
    check("rst_y", 32'(bus_a.y), 32'd0);
    check("rst_z", bus_a.z, 32'd0);
    check("rst_in_ready", 32'(bus_a.in_ready), 32'd1);
    rst = 1'b0;
    tick();

    // Directed vectors, one at a time, LAT=2
    for (int i = 0; i < NVEC; i++) begin
      bus_a.op = vecs[i].op; bus_a.x1 = vecs[i].x1; bus_a.x2 = vecs[i].x2;
      bus_a.in_valid = 1'b1;
      tick();
      bus_a.in_valid = 1'b0;
      check("vec_early_valid", 32'(bus_a.out_valid), 32'd0);
      tick();
      check("vec_valid", 32'(bus_a.out_valid), 32'd1);
      check("vec_y", 32'(bus_a.y), 32'(vecs[i].y));
      check("vec_z", bus_a.z, vecs[i].z);
    end
    tick();

    // Backpressure: 8 MIN ops back to back, out_ready low during cycles 3..6
    begin
      int          sent = 0;
      int          got  = 0;
      logic        prev_stall = 1'b0;
      logic [31:0] prev_z = 32'd0;
      logic        acc;
      for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
        bus_a.out_ready = !(cyc >= 3 && cyc <= 6);
        if (sent < 8) begin
          bus_a.in_valid = 1'b1; bus_a.op = 3'd3;
          bus_a.x1 = 32'h3F800000 + 32'(sent); bus_a.x2 = 32'h40000000;
        end else begin
          bus_a.in_valid = 1'b0;
        end
        #1;
        check("bp_in_ready", 32'(bus_a.in_ready), 32'(!(cyc >= 3 && cyc <= 6)));
        if (prev_stall) begin
          check("bp_hold_valid", 32'(bus_a.out_valid), 32'd1);
          check("bp_hold_z", bus_a.z, prev_z);
        end
        if (bus_a.out_valid && bus_a.out_ready) begin
          check("bp_order", bus_a.z, 32'h3F800000 + 32'(got));
          got++;
        end
        prev_stall = bus_a.out_valid && !bus_a.out_ready;
        prev_z = bus_a.z;
        acc = bus_a.in_valid && bus_a.in_ready;
        tick();
        if (acc) sent++;
      end
      check("bp_count", 32'(got), 32'd8);
      bus_a.in_valid = 1'b0;
      bus_a.out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
        check("bp_no_dup", 32'(bus_a.out_valid), 32'd0);
        tick();
      end
    end

    // Reset with two ops in flight
    bus_a.op = 3'd1; bus_a.x1 = 32'h3F800000; bus_a.x2 = 32'h40000000; bus_a.in_valid = 1'b1;
    tick();
    bus_a.op = 3'd3;
    tick();
    bus_a.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("mrst_out_valid", 32'(bus_a.out_valid), 32'd0);
    check("mrst_y", 32'(bus_a.y), 32'd0);
    check("mrst_z", bus_a.z, 32'd0);
    check("mrst_in_ready", 32'(bus_a.in_ready), 32'd1);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("mrst_flushed", 32'(bus_a.out_valid), 32'd0);
    end

    // LAT=1 / LAT=3 sweep with NAN_EN=0
    for (int i = 0; i < NSW; i++) begin
      sop[i] = 3'($urandom_range(0, 7));
      sx1[i] = rnd_fp();
      case ($urandom_range(0, 3))
        0: sx2[i] = sx1[i];
        1: sx2[i] = sx1[i] ^ 32'h80000000;
        default: sx2[i] = rnd_fp();
      endcase
      sexp[i] = ref_cmp(sop[i], sx1[i], sx2[i], 1'b0);
    end
    sop[0] = 3'd3; sx1[0] = 32'h00000000; sx2[0] = 32'h80000000; sexp[0] = '{1'b0, 32'h00000000};
    sop[1] = 3'd1; sx1[1] = 32'h7F800000; sx2[1] = 32'h7FC00000; sexp[1] = '{1'b1, 32'h0};
    sop[2] = 3'd4; sx1[2] = 32'h7FC00001; sx2[2] = 32'h7FC00000; sexp[2] = '{1'b0, 32'h7FC00001};
    sop[3] = 3'd0; sx1[3] = 32'h7FC00000; sx2[3] = 32'h7FC00000; sexp[3] = '{1'b1, 32'h0};

    for (int t = 0; t < NSW + 4; t++) begin
      if (t < NSW) begin
        bus_b.in_valid = 1'b1; bus_b.op = sop[t]; bus_b.x1 = sx1[t]; bus_b.x2 = sx2[t];
        bus_c.in_valid = 1'b1; bus_c.op = sop[t]; bus_c.x1 = sx1[t]; bus_c.x2 = sx2[t];
      end else begin
        bus_b.in_valid = 1'b0;
        bus_c.in_valid = 1'b0;
      end
      tick();
      check("lat1_valid", 32'(bus_b.out_valid), 32'(t < NSW));
      if (t < NSW) begin
        check("lat1_y", 32'(bus_b.y), 32'(sexp[t].y));
        check("lat1_z", bus_b.z, sexp[t].z);
      end
      check("lat3_valid", 32'(bus_c.out_valid), 32'(t >= 2 && t < NSW + 2));
      if (t >= 2 && t < NSW + 2) begin
        check("lat3_y", 32'(bus_c.y), 32'(sexp[t-2].y));
        check("lat3_z", bus_c.z, sexp[t-2].z);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
